// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, reset/NOP encodings and fetch FSM states
package mips_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {FETCH, HOLD, DROP} fetchState_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold enable and bubble-inserting clear
module if_id_reg import mips_pkg::*; #(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic [XLEN-1:0] instrIn,
  input  logic [XLEN-1:0] pcPlus4In,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);
  // clear beats enable so a flush always lands as a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD <= NOP_INSTR;
      PCPlus4D <= '0;
      ValidD <= 1'b0;
    end else if (clr) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (en) begin
      InstrD <= instrIn;
      PCPlus4D <= pcPlus4In;
      ValidD <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem handshake FSM, skid buffer, stall counter and IF/ID register
module fetch_stage import mips_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENC,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             PCSrcD,
  input  logic [XLEN-1:0]  PCBranchD,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  InstrD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic             ValidD,
  output logic             FetchBusy,
  output logic [CNT_W-1:0] stall_cnt
);
  fetchState_t state, nextState;
  logic [XLEN-1:0] pcF, pcPlus4, skidBuf;
  logic redirect, take;
  assign pcPlus4 = pcF + 32'd4;
  assign redirect = PCSrcD & !StallD;
  assign take = !StallF & (state == HOLD || (state == FETCH && imem_valid));
  assign imem_req = rst_n & (state == FETCH);
  assign imem_addr = pcF;
  assign FetchBusy = (state == DROP) || (state == FETCH && !imem_valid);
  // next state: a redirect abandons any outstanding request via DROP
  always_comb begin
    nextState = state;
    case (state)
      FETCH:   nextState = redirect ? (imem_valid ? FETCH : DROP) : (imem_valid && StallF ? HOLD : FETCH);
      HOLD:    nextState = (redirect || !StallF) ? FETCH : HOLD;
      DROP:    nextState = imem_valid ? FETCH : DROP;
      default: nextState = FETCH;
    endcase
  end
  // state, PC and skid buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pcF <= RESET_PC;
      skidBuf <= '0;
    end else begin
      state <= nextState;
      if (redirect) pcF <= PCBranchD;
      else if (take) pcF <= pcPlus4;
      if (redirect) skidBuf <= '0;
      else if (state == FETCH && imem_valid && StallF) skidBuf <= imem_rdata;
    end
  end
  // saturating count of memory-induced fetch bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (FetchBusy && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_ifId (
    .clk(clk),
    .rst_n(rst_n),
    .en(!StallD && take && !redirect),
    .clr(redirect || (!StallD && !take)),
    .instrIn(state == HOLD ? skidBuf : imem_rdata),
    .pcPlus4In(pcPlus4),
    .InstrD(InstrD),
    .PCPlus4D(PCPlus4D),
    .ValidD(ValidD)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors with hand-computed expectations for fetch_stage
module tb_fetch_stage;
  logic clk = 0, rst_n = 0;
  logic StallF = 0, StallD = 0, PCSrcD = 0, imem_valid = 0;
  logic [31:0] PCBranchD = 0, imem_rdata = 0;
  logic imem_req, ValidD, FetchBusy;
  logic [31:0] imem_addr, InstrD, PCPlus4D;
  logic [15:0] stall_cnt;
  int passCnt = 0, totalCnt = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .FetchBusy(FetchBusy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic v, input logic [31:0] d);
    imem_valid = v;
    imem_rdata = d;
    #1;
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_req", {31'd0, imem_req}, 0);
    chk("rst_instr", InstrD, 32'h0);
    chk("rst_pc4", PCPlus4D, 0);
    chk("rst_valid", {31'd0, ValidD}, 0);
    chk("rst_cnt", {16'd0, stall_cnt}, 0);
    rst_n = 1;
    mem(0, 0);
    chk("a_req", {31'd0, imem_req}, 1);
    chk("a_addr", imem_addr, 0);
    chk("a_busy", {31'd0, FetchBusy}, 1);
    cyc();
    chk("a_valid", {31'd0, ValidD}, 0);
    chk("a_cnt", {16'd0, stall_cnt}, 1);
    mem(1, 32'h2008_0005);
    cyc();
    chk("b_instr", InstrD, 32'h2008_0005);
    chk("b_pc4", PCPlus4D, 4);
    chk("b_valid", {31'd0, ValidD}, 1);
    chk("b_addr", imem_addr, 4);
    mem(1, 32'h8C09_0004);
    cyc();
    chk("c_instr", InstrD, 32'h8C09_0004);
    chk("c_pc4", PCPlus4D, 8);
    for (int i = 0; i < 2; i++) begin
      mem(0, 0);
      chk("w_addr", imem_addr, 8);
      chk("w_busy", {31'd0, FetchBusy}, 1);
      cyc();
      chk("w_valid", {31'd0, ValidD}, 0);
      chk("w_instr", InstrD, 0);
    end
    mem(1, 32'h0000_0888);
    chk("f_addr", imem_addr, 8);
    chk("f_busy", {31'd0, FetchBusy}, 0);
    cyc();
    chk("f_instr", InstrD, 32'h0000_0888);
    chk("f_pc4", PCPlus4D, 32'hC);
    chk("f_cnt", {16'd0, stall_cnt}, 3);
    StallF = 1; StallD = 1;
    mem(1, 32'h0000_0CCC);
    cyc();
    chk("g_req", {31'd0, imem_req}, 0);
    chk("g_instr", InstrD, 32'h0000_0888);
    mem(0, 0);
    chk("h_busy", {31'd0, FetchBusy}, 0);
    cyc();
    chk("h_req", {31'd0, imem_req}, 0);
    chk("h_instr", InstrD, 32'h0000_0888);
    chk("h_pc4", PCPlus4D, 32'hC);
    StallF = 0; StallD = 0;
    cyc();
    chk("i_instr", InstrD, 32'h0000_0CCC);
    chk("i_pc4", PCPlus4D, 32'h10);
    chk("i_valid", {31'd0, ValidD}, 1);
    chk("i_addr", imem_addr, 32'h10);
    chk("i_req", {31'd0, imem_req}, 1);
    PCSrcD = 1; PCBranchD = 32'h40;
    mem(0, 0);
    cyc();
    PCSrcD = 0;
    mem(0, 0);
    chk("j_valid", {31'd0, ValidD}, 0);
    chk("k_req", {31'd0, imem_req}, 0);
    chk("k_busy", {31'd0, FetchBusy}, 1);
    chk("k_addr", imem_addr, 32'h40);
    cyc();
    mem(1, 32'hDEAD_BEEF);
    chk("l_busy", {31'd0, FetchBusy}, 1);
    cyc();
    chk("l_instr", InstrD, 0);
    chk("l_valid", {31'd0, ValidD}, 0);
    chk("l_req", {31'd0, imem_req}, 1);
    chk("l_addr", imem_addr, 32'h40);
    chk("l_cnt", {16'd0, stall_cnt}, 6);
    mem(1, 32'h0000_4040);
    cyc();
    chk("m_instr", InstrD, 32'h0000_4040);
    chk("m_pc4", PCPlus4D, 32'h44);
    StallF = 1; StallD = 1; PCSrcD = 1; PCBranchD = 32'h80;
    mem(0, 0);
    cyc();
    chk("n_addr", imem_addr, 32'h44);
    chk("n_instr", InstrD, 32'h0000_4040);
    chk("n_valid", {31'd0, ValidD}, 1);
    StallF = 0; StallD = 0;
    mem(1, 32'h0000_4444);
    cyc();
    chk("o_addr", imem_addr, 32'h80);
    chk("o_valid", {31'd0, ValidD}, 0);
    chk("o_instr", InstrD, 0);
    chk("o_req", {31'd0, imem_req}, 1);
    PCBranchD = 32'hFFFF_FFFC;
    mem(1, 32'h0000_8080);
    cyc();
    chk("p_addr", imem_addr, 32'hFFFF_FFFC);
    chk("p_valid", {31'd0, ValidD}, 0);
    PCSrcD = 0;
    mem(1, 32'h0000_FCFC);
    cyc();
    chk("q_instr", InstrD, 32'h0000_FCFC);
    chk("q_pc4", PCPlus4D, 0);
    chk("q_valid", {31'd0, ValidD}, 1);
    chk("q_addr", imem_addr, 0);
    chk("q_cnt", {16'd0, stall_cnt}, 7);
    mem(0, 0);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_cnt", {16'd0, stall_cnt}, 32'hFFFF);
    chk("sat_addr", imem_addr, 0);
    chk("sat_valid", {31'd0, ValidD}, 0);
    #2 rst_n = 0;
    #1;
    chk("ar_req", {31'd0, imem_req}, 0);
    chk("ar_cnt", {16'd0, stall_cnt}, 0);
    chk("ar_addr", imem_addr, 0);
    chk("ar_instr", InstrD, 0);
    chk("ar_valid", {31'd0, ValidD}, 0);
    cyc();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined MIPS CPU, sitting directly upstream of the decode stage.
- Owns PCF, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes StallF/StallD from the hazard unit and the decode-resolved branch redirect (PCSrcD/PCBranchD).
- Produces InstrD/PCPlus4D/ValidD for decode.
- Reports memory-induced fetch bubbles via FetchBusy and a saturating stall counter.

Parameters:
RESET_PC, 32'h0000_0000, PCF value loaded on reset.
NOP_INSTR, 32'h0000_0000, encoding driven on InstrD for a bubble (sll $0,$0,0).
CNT_W, 16, width of fetch-stall counter.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
StallF  in  1  hold PCF / do not advance fetch (from hazard unit)
StallD  in  1  hold IF/ID register (from hazard unit)
PCSrcD  in  1  branch taken, resolved in decode
PCBranchD  in  32  branch target
imem_req  out  1  instruction-memory request valid
imem_addr  out  32  request address (= PCF)
imem_valid  in  1  response valid, earliest one cycle after imem_req
imem_rdata  in  32  instruction word, qualified by imem_valid
InstrD  out  32  IF/ID instruction
PCPlus4D  out  32  IF/ID PC+4
ValidD  out  1  IF/ID holds a real instruction (0 = bubble)
FetchBusy  out  1  fetch waiting on memory this cycle
stall_cnt  out  CNT_W  cycles with FetchBusy=1, saturating

Behaviour:
- Reset (rst_n=0, async):
  - PCF=RESET_PC, state=FETCH, skid buffer cleared, stall_cnt=0.
  - InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0.
  - imem_req forced 0 while rst_n=0.
  - Reset mid-transaction abandons the response; memory is required to drop it on reset too.
- Next-PC arithmetic: PCF+4, 32-bit modulo; 32'hFFFF_FFFC wraps to 0. imem_addr=PCF; PCF is stable while the request is outstanding.
- FSM states FETCH, HOLD, DROP:
  - FETCH: imem_req=1.
    - imem_valid & !StallF: IF/ID<=(imem_rdata, PCF+4, 1); PCF<=PCF+4; stay FETCH.
    - imem_valid & StallF: capture rdata into skid buffer, go HOLD (no re-fetch).
    - !imem_valid: FetchBusy=1; if !StallD, IF/ID<=bubble (NOP_INSTR, ValidD=0).
  - HOLD: imem_req=0.
    - !StallF: IF/ID<=(buffer, PCF+4, 1); PCF<=PCF+4; go FETCH.
    - StallF: stay HOLD.
  - DROP: imem_req=0, FetchBusy=1.
    - Wait for the stale imem_valid, discard it, go FETCH (PCF already redirected).
- Redirect (PCSrcD & !StallD):
  - Highest priority after reset.
  - PCF<=PCBranchD; IF/ID<=bubble, which flushes the wrong-path instruction (no delay slot); skid buffer invalidated.
  - From FETCH with no imem_valid: go DROP.
  - From FETCH with imem_valid the same cycle: discard the data, stay FETCH at the new PC.
  - From HOLD: go FETCH.
- PCSrcD while StallD=1 is ignored (branch operands not yet forwarded).
- StallD=1: IF/ID holds all fields, except when overridden by a valid redirect (cannot happen under hazard-unit protocol; assertion).
- Priority: rst_n > redirect > StallD hold > normal load / bubble.
- FetchBusy: combinational, 1 in FETCH without imem_valid and in DROP.
- stall_cnt: +1 per cycle with FetchBusy=1; saturates at all-ones.
- Latency: zero-wait memory (valid the cycle after req) gives one instruction per cycle; PCF to InstrD = 2 cycles.

Decomposition:
- mips_pkg: NOP_INSTR, RESET_PC default, fetch state enum (FETCH/HOLD/DROP), instruction/address widths.
- Sub-module if_id_reg: enable (!StallD), synchronous clear (flush/bubble), async active-low reset; holds InstrD/PCPlus4D/ValidD.
- FSM, PC and counter stay in fetch_stage.

Test Plan:
- Reset release, memory replies 1 cycle after req with 0x20080005 at 0: InstrD=0x20080005, PCPlus4D=4, ValidD=1 two cycles after release; next imem_addr=4.
- Memory wait 3 cycles at PC 8: imem_addr held 8 for 3 cycles, FetchBusy=1 for 2 cycles, ValidD=0 bubbles, stall_cnt +2.
- StallF=StallD=1 for 2 cycles as data arrives at PC 0xC: state HOLD, imem_req=0, InstrD unchanged; on release InstrD=buffered word, PCPlus4D=0x10.
- PCSrcD=1, PCBranchD=0x40 while request to 0x10 outstanding: ValidD=0 next cycle, DROP until stale valid, then imem_addr=0x40; stale word never reaches InstrD.
- PCSrcD=1 with StallD=1: PCF and IF/ID unchanged; redirect taken the cycle StallD drops.
- PCF=0xFFFF_FFFC fetch completes: PCF wraps to 0; rst_n pulse mid-wait: outputs at reset values immediately, imem_req=0, stall_cnt=0.
